// File: rtl/portal_host_xactor.sv
// ============================================================================
// portal_host_xactor: bridges a command/payload stream onto a 4-channel portal
// request port and polls two portal indication channels into a response stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module portal_host_xactor (
  input  logic        CLK,
  input  logic        RST_N,
  // command header and payload
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_chan,
  input  logic [3:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  // portal request side
  output logic [31:0] requestEnqV,
  output logic        EN_request,
  output logic [1:0]  selectRequest,
  input  logic        RDY_requestEnq,
  input  logic        requestNotFull,
  // portal indication side
  output logic [1:0]  selectIndication,
  output logic        EN_indication,
  input  logic        indicationNotEmpty,
  input  logic        RDY_indication,
  input  logic [31:0] indicationData,
  input  logic [31:0] indIntrChannel,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_chan,
  output logic [31:0] rsp_data,
  // statistics
  output logic [15:0] req_words,
  output logic [15:0] ind_words
);

  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} req_state_t;
  typedef enum logic {I_SCAN = 1'b0, I_HOLD = 1'b1} ind_state_t;

  req_state_t  req_state_q, req_state_d;
  logic [1:0]  chan_q, chan_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [15:0] req_words_q, req_words_d;

  ind_state_t  ind_state_q, ind_state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_chan_q, rsp_chan_d;
  logic [15:0] ind_words_q, ind_words_d;

  logic        wdata_xfer;

  // ---------------------------------------------------------------- request
  always_comb begin
    req_state_d   = req_state_q;
    chan_d        = chan_q;
    remaining_d   = remaining_q;
    req_words_d   = req_words_q;
    cmd_ready     = 1'b0;
    wdata_ready   = 1'b0;
    EN_request    = 1'b0;
    selectRequest = 2'd0;
    wdata_xfer    = 1'b0;

    case (req_state_q)
      R_IDLE: begin
        // Gated by RST_N so the header port is closed while reset is held.
        cmd_ready = RST_N;
        if (RST_N && cmd_valid && (cmd_len != 4'd0)) begin
          chan_d      = cmd_chan;
          remaining_d = cmd_len;
          req_state_d = R_SEND;
        end
      end
      R_SEND: begin
        selectRequest = chan_q;
        // Channel 3 has no portal target: payload is drained and dropped.
        if (chan_q == 2'd3) begin
          wdata_ready = 1'b1;
        end else begin
          wdata_ready = RDY_requestEnq && requestNotFull;
        end
        wdata_xfer = wdata_valid && wdata_ready;
        EN_request = wdata_xfer && (chan_q != 2'd3);
        if (wdata_xfer) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            req_state_d = R_IDLE;
          end
        end
      end
      default: req_state_d = R_IDLE;
    endcase

    if (EN_request) begin
      req_words_d = req_words_q + 16'd1;
    end
  end

  assign requestEnqV = wdata;
  assign req_words   = req_words_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_state_q <= R_IDLE;
      chan_q      <= 2'd0;
      remaining_q <= 4'd0;
      req_words_q <= 16'd0;
    end else begin
      req_state_q <= req_state_d;
      chan_q      <= chan_d;
      remaining_q <= remaining_d;
      req_words_q <= req_words_d;
    end
  end

  // ------------------------------------------------------------- indication
  always_comb begin
    ind_state_d   = ind_state_q;
    ptr_d         = ptr_q;
    rsp_data_d    = rsp_data_q;
    rsp_chan_d    = rsp_chan_q;
    ind_words_d   = ind_words_q;
    EN_indication = 1'b0;
    rsp_valid     = 1'b0;

    case (ind_state_q)
      I_SCAN: begin
        if (RST_N && indicationNotEmpty && RDY_indication) begin
          EN_indication = 1'b1;
          rsp_data_d    = indicationData;
          rsp_chan_d    = {1'b0, ptr_q};
          ind_words_d   = ind_words_q + 16'd1;
          ind_state_d   = I_HOLD;
        end else if (indIntrChannel != 32'd0) begin
          // Interrupt value is channel+1, so bit 0 of (value-1) is ~value[0].
          ptr_d = ~indIntrChannel[0];
        end else begin
          ptr_d = ~ptr_q;
        end
      end
      I_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ptr_d       = ~ptr_q;
          ind_state_d = I_SCAN;
        end
      end
      default: ind_state_d = I_SCAN;
    endcase
  end

  assign selectIndication = {1'b0, ptr_q};
  assign rsp_data         = rsp_data_q;
  assign rsp_chan         = rsp_chan_q;
  assign ind_words        = ind_words_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ind_state_q <= I_SCAN;
      ptr_q       <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_chan_q  <= 2'd0;
      ind_words_q <= 16'd0;
    end else begin
      ind_state_q <= ind_state_d;
      ptr_q       <= ptr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_chan_q  <= rsp_chan_d;
      ind_words_q <= ind_words_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_portal_host_xactor.sv
// ============================================================================
// tb_portal_host_xactor: directed self-checking bench for portal_host_xactor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_portal_host_xactor;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_chan;
  logic [3:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [31:0] requestEnqV;
  logic        EN_request;
  logic [1:0]  selectRequest;
  logic        RDY_requestEnq, requestNotFull;
  logic [1:0]  selectIndication;
  logic        EN_indication;
  logic        indicationNotEmpty, RDY_indication;
  logic [31:0] indicationData, indIntrChannel;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_chan;
  logic [31:0] rsp_data;
  logic [15:0] req_words, ind_words;

  // Two-channel portal indication model, muxed by the DUT's select.
  logic        ne [2];
  logic [31:0] idata [2];
  assign indicationNotEmpty = ne[selectIndication[0]];
  assign indicationData     = idata[selectIndication[0]];

  int n_checks = 0;
  int n_err    = 0;
  int pulses;
  logic found;

  always #5 CLK = ~CLK;

  portal_host_xactor dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .requestEnqV(requestEnqV), .EN_request(EN_request), .selectRequest(selectRequest),
    .RDY_requestEnq(RDY_requestEnq), .requestNotFull(requestNotFull),
    .selectIndication(selectIndication), .EN_indication(EN_indication),
    .indicationNotEmpty(indicationNotEmpty), .RDY_indication(RDY_indication),
    .indicationData(indicationData), .indIntrChannel(indIntrChannel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan), .rsp_data(rsp_data),
    .req_words(req_words), .ind_words(ind_words)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    cmd_valid = 0; cmd_chan = 0; cmd_len = 0;
    wdata_valid = 0; wdata = 0;
    RDY_requestEnq = 1; requestNotFull = 1;
    RDY_indication = 1; indIntrChannel = 0; rsp_ready = 0;
    ne[0] = 0; ne[1] = 0; idata[0] = 0; idata[1] = 0;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("rst_wdata_ready", {31'd0, wdata_ready}, 0);
    chk("rst_en_req", {31'd0, EN_request}, 0);
    chk("rst_en_ind", {31'd0, EN_indication}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_sel_ind", {30'd0, selectIndication}, 0);
    chk("rst_req_words", {16'd0, req_words}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    RST_N = 1'b1;
    #1 chk("rel_cmd_ready", {31'd0, cmd_ready}, 1);

    // burst chan 1, len 3, portal always ready
    cmd_valid = 1; cmd_chan = 1; cmd_len = 3;
    tick();
    cmd_valid = 0; wdata_valid = 1; wdata = 32'hA;
    #1 chk("b1_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("b1_sel", {30'd0, selectRequest}, 1);
    chk("b1_en_a", {31'd0, EN_request}, 1);
    chk("b1_enq_a", requestEnqV, 32'hA);
    tick(); wdata = 32'hB;
    #1 chk("b1_en_b", {31'd0, EN_request}, 1);
    chk("b1_enq_b", requestEnqV, 32'hB);
    tick(); wdata = 32'hC;
    #1 chk("b1_en_c", {31'd0, EN_request}, 1);
    chk("b1_enq_c", requestEnqV, 32'hC);
    tick(); wdata_valid = 0;
    #1 chk("b1_req_words", {16'd0, req_words}, 3);
    chk("b1_idle_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("b1_idle_sel", {30'd0, selectRequest}, 0);

    // same burst with a 4-cycle portal stall after the first word
    cmd_valid = 1; cmd_chan = 1; cmd_len = 3;
    tick();
    cmd_valid = 0; wdata_valid = 1; wdata = 32'hA;
    #1 chk("b2_en_a", {31'd0, EN_request}, 1);
    tick(); wdata = 32'hB; RDY_requestEnq = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b2_stall_wready", {31'd0, wdata_ready}, 0);
      chk("b2_stall_en", {31'd0, EN_request}, 0);
      tick();
    end
    RDY_requestEnq = 1;
    #1 chk("b2_en_b", {31'd0, EN_request}, 1);
    chk("b2_enq_b", requestEnqV, 32'hB);
    tick(); wdata = 32'hC;
    #1 chk("b2_enq_c", requestEnqV, 32'hC);
    tick(); wdata_valid = 0;
    #1 chk("b2_req_words", {16'd0, req_words}, 6);

    // chan 3 drain, then a zero-length header
    cmd_valid = 1; cmd_chan = 3; cmd_len = 2;
    tick();
    cmd_valid = 0; wdata_valid = 1; wdata = 32'hD;
    #1 chk("c3_wready_d", {31'd0, wdata_ready}, 1);
    chk("c3_en_d", {31'd0, EN_request}, 0);
    tick(); wdata = 32'hE;
    #1 chk("c3_wready_e", {31'd0, wdata_ready}, 1);
    chk("c3_en_e", {31'd0, EN_request}, 0);
    tick(); wdata_valid = 0;
    #1 chk("c3_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("c3_req_words", {16'd0, req_words}, 6);
    cmd_valid = 1; cmd_chan = 0; cmd_len = 0;
    tick();
    cmd_valid = 0; wdata_valid = 1;
    #1 chk("len0_wready", {31'd0, wdata_ready}, 0);
    chk("len0_en", {31'd0, EN_request}, 0);
    chk("len0_cmd_ready", {31'd0, cmd_ready}, 1);
    wdata_valid = 0;

    // reset in the middle of a burst with two words left
    cmd_valid = 1; cmd_chan = 2; cmd_len = 4;
    tick();
    cmd_valid = 0; wdata_valid = 1; wdata = 32'h11;
    #1 chk("mr_sel", {30'd0, selectRequest}, 2);
    tick(); wdata = 32'h22;
    tick();
    RST_N = 1'b0;
    #1 chk("mr_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("mr_wready", {31'd0, wdata_ready}, 0);
    chk("mr_en_req", {31'd0, EN_request}, 0);
    chk("mr_sel0", {30'd0, selectRequest}, 0);
    chk("mr_req_words", {16'd0, req_words}, 0);
    tick();
    RST_N = 1'b1;
    #1 chk("mr_rel_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("mr_rel_wready", {31'd0, wdata_ready}, 0);
    wdata_valid = 0;
    cmd_valid = 1; cmd_chan = 1; cmd_len = 1;
    tick();
    cmd_valid = 0; wdata_valid = 1; wdata = 32'hF;
    #1 chk("mr_new_en", {31'd0, EN_request}, 1);
    chk("mr_new_enq", requestEnqV, 32'hF);
    tick(); wdata_valid = 0;
    #1 chk("mr_new_words", {16'd0, req_words}, 1);

    // channel 1 holds 0x1234, consumer stalls for 5 cycles
    ne[1] = 1; idata[1] = 32'h1234; rsp_ready = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      #1 if (EN_indication) found = 1; else tick();
    end
    chk("i1_found", {31'd0, found}, 1);
    chk("i1_sel", {30'd0, selectIndication}, 1);
    tick(); ne[1] = 0;
    #1 chk("i1_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("i1_rsp_data", rsp_data, 32'h1234);
    chk("i1_rsp_chan", {30'd0, rsp_chan}, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (EN_indication) pulses++;
      chk("i1_hold_valid", {31'd0, rsp_valid}, 1);
      tick();
    end
    chk("i1_hold_data", rsp_data, 32'h1234);
    chk("i1_extra_deq", pulses, 0);
    rsp_ready = 1;
    tick(); rsp_ready = 0;
    #1 chk("i1_done_valid", {31'd0, rsp_valid}, 0);
    chk("i1_ind_words", {16'd0, ind_words}, 1);

    // both channels busy: dequeues alternate 0,1,0,1
    ne[0] = 1; ne[1] = 1; idata[0] = 32'h100; idata[1] = 32'h101; rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("alt_en", {31'd0, EN_indication}, 1);
      chk("alt_sel", {30'd0, selectIndication}, k % 2);
      tick();
      chk("alt_rsp_chan", {30'd0, rsp_chan}, k % 2);
      chk("alt_rsp_data", rsp_data, 32'h100 + (k % 2));
      tick();
    end
    ne[0] = 0; ne[1] = 0;
    #1 chk("alt_ind_words", {16'd0, ind_words}, 5);

    // interrupt hint steers the poll pointer
    indIntrChannel = 1;
    #1 chk("intr_pre", {30'd0, selectIndication}, 0);
    tick();
    chk("intr1_sel", {30'd0, selectIndication}, 0);
    indIntrChannel = 2;
    tick();
    chk("intr2_sel", {30'd0, selectIndication}, 1);
    tick();
    chk("intr2_sel_hold", {30'd0, selectIndication}, 1);
    indIntrChannel = 0;
    tick();
    chk("intr0_toggle", {30'd0, selectIndication}, 0);

    // reset while a word is held drops it without a re-dequeue
    ne[0] = 1; idata[0] = 32'h55; rsp_ready = 0;
    #1 chk("hr_en", {31'd0, EN_indication}, 1);
    tick(); ne[0] = 0;
    #1 chk("hr_valid", {31'd0, rsp_valid}, 1);
    RST_N = 1'b0;
    #1 chk("hr_rst_valid", {31'd0, rsp_valid}, 0);
    chk("hr_rst_data", rsp_data, 0);
    tick();
    RST_N = 1'b1;
    #1 chk("hr_rel_valid", {31'd0, rsp_valid}, 0);
    chk("hr_rel_en", {31'd0, EN_indication}, 0);
    chk("hr_ind_words", {16'd0, ind_words}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/portal_host_xactor.md
PORTAL_HOST_XACTOR -- requirements
Module: portal_host_xactor

Interface
REQ-001 Parameter: none; all widths fixed as listed.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid/cmd_ready  input/output  1/1  command header handshake.
REQ-005 cmd_chan  input  2  target request channel 0..3; cmd_len  input  4  payload word count 0..15.
REQ-006 wdata_valid/wdata_ready  input/output  1/1  payload word handshake; wdata  input  32  payload word.
REQ-007 requestEnqV  output  32  word to portal; EN_request  output  1  enqueue strobe; selectRequest  output  2  request channel select.
REQ-008 RDY_requestEnq, requestNotFull  input  1 each  portal request readiness for selected channel.
REQ-009 selectIndication  output  2  indication channel select; EN_indication  output  1  dequeue strobe.
REQ-010 indicationNotEmpty, RDY_indication  input  1 each; indicationData  input  32; indIntrChannel  input  32  (0 = no interrupt, else channel+1).
REQ-011 rsp_valid/rsp_ready  output/input  1/1; rsp_chan  output  2; rsp_data  output  32  captured indication word.
REQ-012 req_words, ind_words  output  16 each  wrapping transfer counters.

Function -- request path
REQ-013 Request FSM states R_IDLE, R_SEND; cmd_ready=1 only in R_IDLE; wdata_ready=0 in R_IDLE.
REQ-014 R_IDLE, cmd_valid, cmd_len!=0 -> latch chan, remaining=cmd_len, go R_SEND next cycle.
REQ-015 R_IDLE, cmd_valid, cmd_len==0 -> header consumed, stay R_IDLE, no EN_request.
REQ-016 selectRequest = latched chan in R_SEND, 0 in R_IDLE.
REQ-017 R_SEND, chan 0..2: wdata_ready = RDY_requestEnq && requestNotFull; EN_request = wdata_valid && wdata_ready; requestEnqV = wdata (combinational, zero-latency pass-through).
REQ-018 R_SEND, chan 3: wdata_ready=1, words drained and discarded, EN_request never asserted.
REQ-019 Each wdata transfer decrements remaining; transfer with remaining==1 -> R_IDLE next cycle; back-to-back commands thus have one idle header cycle between bursts.
REQ-020 req_words increments by 1 per EN_request cycle, wraps 0xFFFF->0.

Function -- indication path
REQ-021 Indication FSM states I_SCAN, I_HOLD; 1-bit poll pointer ptr; selectIndication = {1'b0, ptr} always.
REQ-022 I_SCAN: if indicationNotEmpty && RDY_indication -> EN_indication=1 for exactly that cycle, rsp_data<=indicationData, rsp_chan<={1'b0,ptr}, go I_HOLD.
REQ-023 I_SCAN, no word available: if indIntrChannel!=0, ptr<=indIntrChannel-1 bit 0; else ptr toggles.
REQ-024 I_HOLD: rsp_valid=1, EN_indication=0; rsp_ready -> I_SCAN next cycle, ptr toggles (fairness); rsp_data/rsp_chan stable while rsp_valid && !rsp_ready.
REQ-025 Latency: rsp_valid rises the cycle after EN_indication; minimum 2 cycles between successive EN_indication pulses.
REQ-026 ind_words increments by 1 per EN_indication cycle, wraps 0xFFFF->0.
REQ-027 Request and indication paths fully independent; simultaneous activity permitted every cycle.

Reset
REQ-028 RST_N low asynchronously forces R_IDLE, I_SCAN, ptr=0, remaining=0, req_words=0, ind_words=0, rsp_data=0, rsp_chan=0.
REQ-029 During reset: cmd_ready=0, wdata_ready=0, EN_request=0, EN_indication=0, rsp_valid=0, selectRequest=0, selectIndication=0.
REQ-030 Reset mid-burst discards remaining words; first cycle after release cmd_ready=1.
REQ-031 Reset during I_HOLD drops the held word; no re-dequeue.

Verification
REQ-032 cmd chan=1 len=3, words 0xA,0xB,0xC, portal always ready -> EN_request three consecutive cycles, selectRequest=1, requestEnqV A,B,C, req_words=3.
REQ-033 Same burst, RDY_requestEnq low 4 cycles mid-burst -> wdata_ready=0, no EN_request while low, order preserved, no loss.
REQ-034 cmd chan=3 len=2 -> 2 words accepted, EN_request never high, req_words unchanged; cmd len=0 -> no wdata_ready.
REQ-035 Channel 1 not-empty with 0x1234, rsp_ready low 5 cycles -> single EN_indication, rsp_valid held, rsp_data=0x1234, rsp_chan=1.
REQ-036 Both channels continuously not-empty -> dequeues alternate 0,1,0,1; indIntrChannel=1 in I_SCAN with none available -> next select 0.
REQ-037 RST_N asserted during R_SEND with remaining=2 -> all outputs per REQ-029 immediately, new command accepted cycle after release.
